// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the system writer, the TX FIFO and the UART transmitter.
// The master side is whoever drives push and the transmitter status lines.
interface uart_tx_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  push;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  full;
   logic                  empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_start;
   logic                  tx_busy;
   logic                  tx_done;

   modport master (
      output push, push_data, tx_busy, tx_done,
      input  full, empty, count, overflow, tx_data, tx_start
   );

   modport slave (
      input  push, push_data, tx_busy, tx_done,
      output full, empty, count, overflow, tx_data, tx_start
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter one frame at a time.
// A new byte is launched only once the previous frame has reported tx_done.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_fifo_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT
   } state_t;

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

   state_t                state;
   state_t                next_state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  pop;
   logic                  push_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The pop decision looks only at registered count, so a push into an
   // empty FIFO can never be launched in the same cycle.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (count_q != '0 && !bus.tx_busy) begin
               next_state = LAUNCH;
               pop        = 1'b1;
            end
         end
         LAUNCH: next_state = WAIT;
         WAIT: begin
            if (bus.tx_done) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
   always_comb begin
      push_ok    = bus.push && (count_q != FULL_COUNT || pop);
      count_next = count_q;
      if (push_ok && !pop) begin
         count_next = count_q + 1'b1;
      end else if (pop && !push_ok) begin
         count_next = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count_q      <= '0;
         bus.tx_data  <= '0;
         bus.tx_start <= 1'b0;
         bus.overflow <= 1'b0;
         bus.empty    <= 1'b1;
         bus.full     <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            bus.tx_data <= mem[rd_ptr];
         end
         count_q      <= count_next;
         bus.tx_start <= pop;
         bus.overflow <= bus.push && !push_ok;
         bus.empty    <= (count_next == '0);
         bus.full     <= (count_next == FULL_COUNT);
      end
   end

   // Storage has no reset; a simultaneous push+pop on a full FIFO reads the old word.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= bus.push_data;
      end
   end

   assign bus.count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a behavioural transmitter logs every
// launched byte, and each test compares that log with the bytes it pushed.
module tb_uart_tx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         total_checks  = 0;
   int         passed_checks = 0;
   bit         hold_busy     = 1'b0;
   int         frame_min     = 1;
   int         frame_max     = 5;
   int         cyc           = 0;
   int         frame_left    = 0;
   int         proto_errors  = 0;
   bit         in_frame      = 1'b0;
   logic [7:0] rx_log [$];
   int         launch_cyc [$];
   int         done_cyc [$];

   // Transmitter model: acts on the falling edge, so it never races the bench
   // process that drives push and samples just after the rising edge.
   initial begin : tx_model
      bus.tx_busy = 1'b0;
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         bus.tx_done = 1'b0;
         if (rst) begin
            in_frame   = 1'b0;
            frame_left = 0;
         end else begin
            if (in_frame) begin
               frame_left--;
               if (frame_left == 0) begin
                  in_frame    = 1'b0;
                  bus.tx_done = 1'b1;
                  done_cyc.push_back(cyc);
               end
            end
            if (bus.tx_start) begin
               if (in_frame) proto_errors++;
               rx_log.push_back(bus.tx_data);
               launch_cyc.push_back(cyc);
               in_frame   = 1'b1;
               frame_left = $urandom_range(frame_max, frame_min);
            end
         end
         bus.tx_busy = hold_busy || in_frame;
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d);
      bus.push      = 1'b1;
      bus.push_data = d;
      tick();
      bus.push      = 1'b0;
   endtask

   task automatic wait_drain(output bit ok);
      int quiet;
      quiet = 0;
      ok    = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (bus.empty && !bus.tx_busy && !bus.tx_start) quiet++;
         else quiet = 0;
         if (quiet >= 3) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      bit seen;
      int base;
      total_checks++;
      if (bus.count !== 5'd0) $display("[TB] FAIL reset_count: got %0d, expected 0", bus.count);
      else passed_checks++;
      total_checks++;
      if (bus.empty !== 1'b1 || bus.full !== 1'b0) $display("[TB] FAIL reset_flags: empty=%b full=%b, expected 1 0", bus.empty, bus.full);
      else passed_checks++;
      total_checks++;
      if (bus.tx_start !== 1'b0 || bus.overflow !== 1'b0 || bus.tx_data !== 8'h00) $display("[TB] FAIL reset_tx: tx_start=%b overflow=%b tx_data=%h, expected 0 0 00", bus.tx_start, bus.overflow, bus.tx_data);
      else passed_checks++;
      rst = 1'b0;
      tick();

      // Start a long frame with two bytes queued behind it, then reset mid-frame.
      frame_min = 8;
      frame_max = 8;
      hold_busy = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) push_byte(8'($urandom));
      hold_busy = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         seen = bus.tx_start;
      end
      total_checks++;
      if (!seen) $display("[TB] FAIL reset_prelaunch: tx_start=0 after 20 cycles, expected a launch");
      else passed_checks++;
      tick();
      total_checks++;
      if (bus.count !== 5'd2) $display("[TB] FAIL reset_midcount: got %0d, expected 2", bus.count);
      else passed_checks++;
      rst = 1'b1;
      tick();
      total_checks++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) $display("[TB] FAIL reset_mid_flags: count=%0d empty=%b full=%b, expected 0 1 0", bus.count, bus.empty, bus.full);
      else passed_checks++;
      total_checks++;
      if (bus.tx_start !== 1'b0 || bus.overflow !== 1'b0 || bus.tx_data !== 8'h00) $display("[TB] FAIL reset_mid_tx: tx_start=%b overflow=%b tx_data=%h, expected 0 0 00", bus.tx_start, bus.overflow, bus.tx_data);
      else passed_checks++;
      rst = 1'b0;
      frame_min = 1;
      frame_max = 5;
      tick();

      base = rx_log.size();
      push_byte(8'h55);
      tick();
      total_checks++;
      if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h55) $display("[TB] FAIL reset_relaunch: tx_start=%b tx_data=%h, expected 1 55", bus.tx_start, bus.tx_data);
      else passed_checks++;
      wait_drain(ok);
      total_checks++;
      if (!ok || rx_log.size() - base != 1) $display("[TB] FAIL reset_discard: drained=%b sent=%0d, expected 1 1", ok, rx_log.size() - base);
      else passed_checks++;
   endtask

   task automatic test_single_byte();
      bit ok;
      int extra;
      frame_min = 10;
      frame_max = 10;
      push_byte(8'hA5);
      total_checks++;
      if (bus.count !== 5'd1 || bus.tx_start !== 1'b0) $display("[TB] FAIL single_edge_n: count=%0d tx_start=%b, expected 1 0", bus.count, bus.tx_start);
      else passed_checks++;
      tick();
      total_checks++;
      if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5 || bus.count !== 5'd0) $display("[TB] FAIL single_launch: tx_start=%b tx_data=%h count=%0d, expected 1 a5 0", bus.tx_start, bus.tx_data, bus.count);
      else passed_checks++;
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.tx_start) extra++;
      end
      total_checks++;
      if (extra != 0) $display("[TB] FAIL single_no_restart: got %0d extra starts, expected 0", extra);
      else passed_checks++;
      wait_drain(ok);
      total_checks++;
      if (!ok || bus.tx_data !== 8'hA5) $display("[TB] FAIL single_hold: drained=%b tx_data=%h, expected 1 a5", ok, bus.tx_data);
      else passed_checks++;
      frame_min = 1;
      frame_max = 5;
   endtask

   task automatic test_back_to_back();
      bit ok;
      int base;
      int lbase;
      int dbase;
      base  = rx_log.size();
      lbase = launch_cyc.size();
      dbase = done_cyc.size();
      for (int i = 1; i <= 16; i++) push_byte(8'(i));
      wait_drain(ok);
      total_checks++;
      if (!ok || rx_log.size() - base != 16) $display("[TB] FAIL burst_len: drained=%b sent=%0d, expected 1 16", ok, rx_log.size() - base);
      else passed_checks++;
      for (int i = 0; i < 16 && base + i < rx_log.size(); i++) begin
         total_checks++;
         if (rx_log[base+i] !== 8'(i + 1)) $display("[TB] FAIL burst_order[%0d]: got %h, expected %h", i, rx_log[base+i], 8'(i + 1));
         else passed_checks++;
      end
      for (int i = 1; i < 16 && lbase + i < launch_cyc.size() && dbase + i - 1 < done_cyc.size(); i++) begin
         total_checks++;
         if (launch_cyc[lbase+i] - done_cyc[dbase+i-1] != 2) $display("[TB] FAIL burst_gap[%0d]: got %0d cycles, expected 2", i, launch_cyc[lbase+i] - done_cyc[dbase+i-1]);
         else passed_checks++;
      end
   endtask

   task automatic test_overflow();
      bit ok;
      int base;
      base = rx_log.size();
      hold_busy = 1'b1;
      tick();
      for (int i = 1; i <= 16; i++) begin
         push_byte(8'(i));
         if (i == 15) begin
            total_checks++;
            if (bus.full !== 1'b0 || bus.count !== 5'd15) $display("[TB] FAIL ovf_15: full=%b count=%0d, expected 0 15", bus.full, bus.count);
            else passed_checks++;
         end
      end
      total_checks++;
      if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b0) $display("[TB] FAIL ovf_16: full=%b count=%0d overflow=%b, expected 1 16 0", bus.full, bus.count, bus.overflow);
      else passed_checks++;
      push_byte(8'd17);
      total_checks++;
      if (bus.overflow !== 1'b1 || bus.count !== 5'd16) $display("[TB] FAIL ovf_17: overflow=%b count=%0d, expected 1 16", bus.overflow, bus.count);
      else passed_checks++;
      tick();
      total_checks++;
      if (bus.overflow !== 1'b0) $display("[TB] FAIL ovf_pulse: overflow=%b, expected 0", bus.overflow);
      else passed_checks++;
      hold_busy = 1'b0;
      wait_drain(ok);
      total_checks++;
      if (!ok || rx_log.size() - base != 16) $display("[TB] FAIL ovf_len: drained=%b sent=%0d, expected 1 16", ok, rx_log.size() - base);
      else passed_checks++;
      for (int i = 0; i < 16 && base + i < rx_log.size(); i++) begin
         total_checks++;
         if (rx_log[base+i] !== 8'(i + 1)) $display("[TB] FAIL ovf_order[%0d]: got %h, expected %h", i, rx_log[base+i], 8'(i + 1));
         else passed_checks++;
      end
   endtask

   task automatic test_full_push_pop();
      bit         ok;
      int         base;
      logic [7:0] expq [$];
      logic [7:0] d;
      base = rx_log.size();
      hold_busy = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
         d = 8'($urandom);
         expq.push_back(d);
         push_byte(d);
      end
      expq.push_back(8'hEE);
      // Releasing busy and pushing together makes the pop land on the push edge.
      hold_busy     = 1'b0;
      bus.push      = 1'b1;
      bus.push_data = 8'hEE;
      tick();
      bus.push = 1'b0;
      total_checks++;
      if (bus.count !== 5'd16 || bus.overflow !== 1'b0 || bus.full !== 1'b1) $display("[TB] FAIL fpp_count: count=%0d overflow=%b full=%b, expected 16 0 1", bus.count, bus.overflow, bus.full);
      else passed_checks++;
      total_checks++;
      if (bus.tx_start !== 1'b1 || bus.tx_data !== expq[0]) $display("[TB] FAIL fpp_launch: tx_start=%b tx_data=%h, expected 1 %h", bus.tx_start, bus.tx_data, expq[0]);
      else passed_checks++;
      wait_drain(ok);
      total_checks++;
      if (!ok || rx_log.size() - base != 17) $display("[TB] FAIL fpp_len: drained=%b sent=%0d, expected 1 17", ok, rx_log.size() - base);
      else passed_checks++;
      for (int i = 0; i < 17 && base + i < rx_log.size(); i++) begin
         total_checks++;
         if (rx_log[base+i] !== expq[i]) $display("[TB] FAIL fpp_order[%0d]: got %h, expected %h", i, rx_log[base+i], expq[i]);
         else passed_checks++;
      end
   endtask

   task automatic test_wrap_around();
      bit         ok;
      int         base;
      logic [7:0] expq [$];
      logic [7:0] d;
      base = rx_log.size();
      for (int r = 0; r < 3; r++) begin
         if (r == 1) begin
            hold_busy = 1'b1;
            tick();
         end
         for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            expq.push_back(d);
            push_byte(d);
            total_checks++;
            if (bus.overflow !== 1'b0) $display("[TB] FAIL wrap_ovf[%0d]: overflow=%b, expected 0", r * 12 + i, bus.overflow);
            else passed_checks++;
            repeat ($urandom_range(2, 0)) tick();
         end
         if (r == 1) begin
            total_checks++;
            if (bus.count !== 5'd12 || bus.full !== 1'b0) $display("[TB] FAIL wrap_held: count=%0d full=%b, expected 12 0", bus.count, bus.full);
            else passed_checks++;
            hold_busy = 1'b0;
         end
         wait_drain(ok);
         total_checks++;
         if (!ok) $display("[TB] FAIL wrap_drain[%0d]: drained=0, expected 1", r);
         else passed_checks++;
      end
      total_checks++;
      if (rx_log.size() - base != 36 || bus.empty !== 1'b1) $display("[TB] FAIL wrap_len: sent=%0d empty=%b, expected 36 1", rx_log.size() - base, bus.empty);
      else passed_checks++;
      for (int i = 0; i < 36 && base + i < rx_log.size(); i++) begin
         total_checks++;
         if (rx_log[base+i] !== expq[i]) $display("[TB] FAIL wrap_order[%0d]: got %h, expected %h", i, rx_log[base+i], expq[i]);
         else passed_checks++;
      end
   endtask

   initial begin : main
      bus.push      = 1'b0;
      bus.push_data = 8'h00;
      rst           = 1'b1;
      repeat (3) tick();
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_full_push_pop();
      test_wrap_around();
      total_checks++;
      if (proto_errors != 0) $display("[TB] FAIL protocol: got %0d launches during a frame, expected 0", proto_errors);
      else passed_checks++;
      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
